fractal_sync_credit_sched: RTL and testbench
============================================

// Module: fractal_sync_credit_sched
// PURPOSE
//  Credit-based round-robin scheduler that drains IN_PORTS sync-request FIFOs onto OUT_PORTS
//  downstream links of a fractal sync tree node. Unlike a plain per-cycle arbiter it tracks
//  downstream buffer space with per-link credits and never issues into a link without credit.
//  Output is registered (one stage); sits between the node input FIFOs and the up/down links.
// PARAMETERS
//  IN_PORTS   4   number of input FIFOs (>0)
//  OUT_PORTS  2   number of output links (>0, <= IN_PORTS)
//  CREDITS    4   initial/maximum credits per output link (>0); CNT_W = $clog2(CREDITS+1)
//  DATA_W     8   width of one sync element
// PORTS
//  clk_i      in   1                  clock
//  rst_ni     in   1                  reset, asynchronous, active-low
//  enable_i   in   1                  1: scheduling allowed; 0: no new grants
//  empty_i    in   IN_PORTS           per-FIFO empty flag
//  pop_o      out  IN_PORTS           per-FIFO pop, combinational, same cycle as grant
//  element_i  in   IN_PORTS x DATA_W  FIFO head elements
//  valid_o    out  OUT_PORTS          registered element valid, one-cycle pulse per element
//  element_o  out  OUT_PORTS x DATA_W registered element, '0 when valid_o=0
//  credit_i   in   OUT_PORTS          one credit returned per high cycle per link
//  credits_o  out  OUT_PORTS x CNT_W  current credit count per link
//  err_o      out  1                  sticky credit-overflow error
// BEHAVIOUR
//  Reset: valid_o=0, element_o='0, credits=CREDITS on every link, rr_ptr=0, err_o=0; pop_o=0.
//  Request: input j pending iff !empty_i[j]. Each FIFO popped at most once per cycle.
//  Eligible link i: credit[i]>0 and enable_i=1. Eligible links served in ascending index.
//  Grant scan per link: first pending, not-yet-granted input searching from rr_ptr upward,
//   wrapping at IN_PORTS-1 -> 0. Granted input j: pop_o[j]=1 same cycle, element_i[j] captured
//   into link i output register; valid_o[i]=1 next cycle.
//  Links with no eligible credit or no remaining requester: valid_o[i]=0, element_o[i]='0 next cycle.
//  rr_ptr: if >=1 grant this cycle, rr_ptr <= (last granted index + 1) mod IN_PORTS; else hold.
//  Latency: grant-to-valid_o exactly 1 cycle; no backpressure on valid_o (credits guarantee space).
//  Credit counter per link, next = cur - grant[i] + credit_i[i]:
//   grant and credit_i same cycle -> unchanged; credit=0 -> no grant on that link.
//   credit_i when count==CREDITS -> count stays CREDITS, err_o <= 1 (sticky until reset).
//  enable_i=0: no pops, no grants, counters still accept credit_i, registered outputs clear
//   next cycle (element already issued is not withdrawn).
//  Reset mid-operation: all state returns to reset values asynchronously; in-flight registered
//   element is dropped; credits re-initialised (downstream is reset on the same rst_ni).
//  More pending inputs than eligible links: excess inputs wait; round-robin prevents starvation:
//   any continuously pending input is granted within ceil(IN_PORTS/OUT_PORTS) granting cycles.
// TESTING
//  T1 reset: release rst_ni, all empty -> valid_o=0, pop_o=0, credits_o={4,4}, err_o=0.
//  T2 fairness: IN=4,OUT=2, all FIFOs non-empty, credit_i tied high -> cycle grants {0,1},{2,3},
//     {0,1}...; each pop_o[j] pulses every 2nd cycle; valid_o both high from cycle 2 on.
//  T3 credit exhaustion: only FIFO 0 non-empty, credit_i=0 -> exactly 4 pops then stall,
//     credits_o[0]=0; one credit_i[0] pulse -> exactly one more pop, valid_o[0] one cycle later.
//  T4 simultaneous grant+credit: credits_o[0]=2, grant and credit_i[0] same cycle -> stays 2.
//  T5 overflow: idle, credits=4, pulse credit_i[1] -> credits_o[1]=4, err_o=1 and stays 1.
//  T6 enable/reset mid-op: drop enable_i during T2 -> pop_o=0 same cycle, valid_o=0 next cycle;
//     assert rst_ni low mid-stream -> outputs cleared immediately, credits back to 4.

Source files
------------

// File: rtl/fractal_sync_credit_sched.sv
// -----------------------------------------------------------------------------
// fractal_sync_credit_sched
//
// Credit-based round-robin scheduler for a fractal sync tree node. It drains
// IN_PORTS sync-request FIFOs onto OUT_PORTS downstream links. Each link has a
// credit counter that tracks free downstream buffer space. A link never issues
// an element while its counter is zero.
//
// Ports:
//   clk_i      clock
//   rst_ni     asynchronous active-low reset
//   enable_i   1: new grants allowed, 0: no pops and no grants
//   empty_i    per-FIFO empty flag; input j requests when empty_i[j] = 0
//   pop_o      per-FIFO pop, combinational, asserted in the grant cycle
//   element_i  FIFO head elements, packed: FIFO j at [j*DATA_W +: DATA_W]
//   valid_o    registered per-link valid, one-cycle pulse per element
//   element_o  registered per-link element, packed per link, '0 when not valid
//   credit_i   per-link credit return, one credit per high cycle
//   credits_o  per-link credit count, packed: link i at [i*CNT_W +: CNT_W]
//   err_o      sticky flag: a credit came back while the counter was full
// -----------------------------------------------------------------------------
module fractal_sync_credit_sched #(
    parameter int unsigned IN_PORTS   = 4,
    parameter int unsigned OUT_PORTS  = 2,
    parameter int unsigned CREDITS    = 4,
    parameter int unsigned DATA_W     = 8,
    localparam int unsigned CNT_W     = $clog2(CREDITS + 1),
    localparam int unsigned PTR_W     = (IN_PORTS > 1) ? $clog2(IN_PORTS) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          enable_i,
    input  logic [IN_PORTS-1:0]           empty_i,
    output logic [IN_PORTS-1:0]           pop_o,
    input  logic [IN_PORTS*DATA_W-1:0]    element_i,
    output logic [OUT_PORTS-1:0]          valid_o,
    output logic [OUT_PORTS*DATA_W-1:0]   element_o,
    input  logic [OUT_PORTS-1:0]          credit_i,
    output logic [OUT_PORTS*CNT_W-1:0]    credits_o,
    output logic                          err_o
);

    logic [PTR_W-1:0]            rr_ptr_r;
    logic [PTR_W-1:0]            rr_ptr_s;
    logic [CNT_W-1:0]            credit_r [OUT_PORTS];
    logic [CNT_W-1:0]            credit_s [OUT_PORTS];
    logic [OUT_PORTS-1:0]        grant_s;
    logic [OUT_PORTS-1:0]        valid_r;
    logic [OUT_PORTS*DATA_W-1:0] elem_s;
    logic [OUT_PORTS*DATA_W-1:0] elem_r;
    logic [IN_PORTS-1:0]         taken_s;
    logic                        err_r;
    logic                        err_set_s;

    // Distance of input j from the round-robin pointer, modulo IN_PORTS.
    // Scanning distances 0..IN_PORTS-1 visits inputs from rr_ptr upward with wrap.
    function automatic int rr_dist(input int j, input logic [PTR_W-1:0] ptr);
        int d;
        d = j - int'(ptr);
        if (d < 0) begin
            d = d + int'(IN_PORTS);
        end else begin
            d = d;
        end
        return d;
    endfunction

    // Grant scan: eligible links in ascending order, each one picks the first
    // pending input not yet taken by a lower link. Later grants overwrite
    // rr_ptr_s, so it ends as (last granted index + 1) mod IN_PORTS. Gating
    // with rst_ni keeps pop_o low while reset is held.
    always_comb begin
        taken_s  = '0;
        grant_s  = '0;
        elem_s   = '0;
        rr_ptr_s = rr_ptr_r;
        for (int i = 0; i < OUT_PORTS; i++) begin
            if (rst_ni && enable_i && (credit_r[i] != '0)) begin
                for (int k = 0; k < IN_PORTS; k++) begin
                    for (int j = 0; j < IN_PORTS; j++) begin
                        if (!grant_s[i] && !empty_i[j] && !taken_s[j] &&
                            (rr_dist(j, rr_ptr_r) == k)) begin
                            grant_s[i] = 1'b1;
                            taken_s[j] = 1'b1;
                            elem_s[i*DATA_W +: DATA_W] = element_i[j*DATA_W +: DATA_W];
                            if (j == int'(IN_PORTS) - 1) begin
                                rr_ptr_s = '0;
                            end else begin
                                rr_ptr_s = PTR_W'(j + 1);
                            end
                        end else begin
                            // input not selected at this scan distance
                        end
                    end
                end
            end else begin
                // link idle: no credit, disabled, or in reset
            end
        end
    end

    // Credit update: next = cur - grant + credit_i. A return into a full
    // counter is dropped and flags the sticky error.
    always_comb begin
        err_set_s = 1'b0;
        for (int i = 0; i < OUT_PORTS; i++) begin
            credit_s[i] = credit_r[i];
            if (grant_s[i] && !credit_i[i]) begin
                credit_s[i] = credit_r[i] - CNT_W'(1'b1);
            end else if (!grant_s[i] && credit_i[i]) begin
                if (credit_r[i] == CNT_W'(CREDITS)) begin
                    err_set_s = 1'b1;
                end else begin
                    credit_s[i] = credit_r[i] + CNT_W'(1'b1);
                end
            end else begin
                credit_s[i] = credit_r[i];
            end
        end
    end

    // State and output registers. Reset drops any in-flight element and
    // refills credits, since downstream is reset by the same rst_ni.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_r <= '0;
            valid_r  <= '0;
            elem_r   <= '0;
            err_r    <= 1'b0;
            for (int i = 0; i < OUT_PORTS; i++) begin
                credit_r[i] <= CNT_W'(CREDITS);
            end
        end else begin
            rr_ptr_r <= rr_ptr_s;
            valid_r  <= grant_s;
            elem_r   <= elem_s;
            err_r    <= err_r | err_set_s;
            for (int i = 0; i < OUT_PORTS; i++) begin
                credit_r[i] <= credit_s[i];
            end
        end
    end

    assign pop_o     = taken_s;
    assign valid_o   = valid_r;
    assign element_o = elem_r;
    assign err_o     = err_r;

    for (genvar g = 0; g < OUT_PORTS; g++) begin : g_credits_out
        assign credits_o[g*CNT_W +: CNT_W] = credit_r[g];
    end

endmodule

// File: tb/tb_fractal_sync_credit_sched.sv
// -----------------------------------------------------------------------------
// Testbench for fractal_sync_credit_sched (IN_PORTS=4, OUT_PORTS=2, CREDITS=4,
// DATA_W=8). A per-cycle vector table covers fairness, enable drop, credit
// exhaustion, credit return, simultaneous grant+credit and pointer wrap.
// Hand-written sequences cover asynchronous reset mid-stream and overflow.
// FIFO j always presents element 8'h11*(j+1).
// -----------------------------------------------------------------------------
module tb_fractal_sync_credit_sched;

    logic        clk_i;
    logic        rst_ni;
    logic        enable_i;
    logic [3:0]  empty_i;
    logic [3:0]  pop_o;
    logic [31:0] element_i;
    logic [1:0]  valid_o;
    logic [15:0] element_o;
    logic [1:0]  credit_i;
    logic [5:0]  credits_o;
    logic        err_o;

    int checks;
    int errors;

    fractal_sync_credit_sched #(
        .IN_PORTS  (4),
        .OUT_PORTS (2),
        .CREDITS   (4),
        .DATA_W    (8)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .enable_i  (enable_i),
        .empty_i   (empty_i),
        .pop_o     (pop_o),
        .element_i (element_i),
        .valid_o   (valid_o),
        .element_o (element_o),
        .credit_i  (credit_i),
        .credits_o (credits_o),
        .err_o     (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0]  empty;
        logic [1:0]  credit;
        logic        en;
        logic [3:0]  pop;
        logic [1:0]  valid;
        logic [15:0] elem;
        logic [2:0]  c0;
        logic [2:0]  c1;
        logic        err;
    } vec_t;

    vec_t tbl [21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_ni    = 1'b0;
        enable_i  = 1'b1;
        empty_i   = 4'b1111;
        credit_i  = 2'b00;
        element_i = 32'h44332211;

        //          empty    credit en    | pop      valid  elem      c0    c1    err
        tbl[0]  = '{4'b0000, 2'b11, 1'b1, 4'b0011, 2'b11, 16'h2211, 3'd4, 3'd4, 1'b0};
        tbl[1]  = '{4'b0000, 2'b11, 1'b1, 4'b1100, 2'b11, 16'h4433, 3'd4, 3'd4, 1'b0};
        tbl[2]  = '{4'b0000, 2'b11, 1'b1, 4'b0011, 2'b11, 16'h2211, 3'd4, 3'd4, 1'b0};
        tbl[3]  = '{4'b0000, 2'b00, 1'b0, 4'b0000, 2'b00, 16'h0000, 3'd4, 3'd4, 1'b0};
        tbl[4]  = '{4'b0000, 2'b00, 1'b1, 4'b1100, 2'b11, 16'h4433, 3'd3, 3'd3, 1'b0};
        tbl[5]  = '{4'b1110, 2'b00, 1'b1, 4'b0001, 2'b01, 16'h0011, 3'd2, 3'd3, 1'b0};
        tbl[6]  = '{4'b1110, 2'b00, 1'b1, 4'b0001, 2'b01, 16'h0011, 3'd1, 3'd3, 1'b0};
        tbl[7]  = '{4'b1110, 2'b00, 1'b1, 4'b0001, 2'b01, 16'h0011, 3'd0, 3'd3, 1'b0};
        tbl[8]  = '{4'b1110, 2'b00, 1'b1, 4'b0001, 2'b10, 16'h1100, 3'd0, 3'd2, 1'b0};
        tbl[9]  = '{4'b1110, 2'b00, 1'b1, 4'b0001, 2'b10, 16'h1100, 3'd0, 3'd1, 1'b0};
        tbl[10] = '{4'b1110, 2'b00, 1'b1, 4'b0001, 2'b10, 16'h1100, 3'd0, 3'd0, 1'b0};
        tbl[11] = '{4'b1110, 2'b00, 1'b1, 4'b0000, 2'b00, 16'h0000, 3'd0, 3'd0, 1'b0};
        tbl[12] = '{4'b1110, 2'b01, 1'b1, 4'b0000, 2'b00, 16'h0000, 3'd1, 3'd0, 1'b0};
        tbl[13] = '{4'b1110, 2'b00, 1'b1, 4'b0001, 2'b01, 16'h0011, 3'd0, 3'd0, 1'b0};
        tbl[14] = '{4'b1110, 2'b00, 1'b1, 4'b0000, 2'b00, 16'h0000, 3'd0, 3'd0, 1'b0};
        tbl[15] = '{4'b1111, 2'b11, 1'b1, 4'b0000, 2'b00, 16'h0000, 3'd1, 3'd1, 1'b0};
        tbl[16] = '{4'b1111, 2'b01, 1'b1, 4'b0000, 2'b00, 16'h0000, 3'd2, 3'd1, 1'b0};
        tbl[17] = '{4'b1110, 2'b01, 1'b1, 4'b0001, 2'b01, 16'h0011, 3'd2, 3'd1, 1'b0};
        tbl[18] = '{4'b0000, 2'b00, 1'b1, 4'b0110, 2'b11, 16'h3322, 3'd1, 3'd0, 1'b0};
        tbl[19] = '{4'b0000, 2'b11, 1'b1, 4'b1000, 2'b01, 16'h0044, 3'd1, 3'd1, 1'b0};
        tbl[20] = '{4'b0000, 2'b00, 1'b1, 4'b0011, 2'b11, 16'h2211, 3'd0, 3'd0, 1'b0};

        // T1: reset and idle
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check("reset_valid",   {30'd0, valid_o},   32'd0);
        check("reset_pop",     {28'd0, pop_o},     32'd0);
        check("reset_elem",    {16'd0, element_o}, 32'd0);
        check("reset_credits", {26'd0, credits_o}, {26'd0, 3'd4, 3'd4});
        check("reset_err",     {31'd0, err_o},     32'd0);

        // T2/T3/T4 and enable drop: one table row per clock cycle
        for (int v = 0; v < 21; v++) begin
            empty_i  = tbl[v].empty;
            credit_i = tbl[v].credit;
            enable_i = tbl[v].en;
            #1;
            check($sformatf("v%0d_pop", v), {28'd0, pop_o}, {28'd0, tbl[v].pop});
            @(posedge clk_i);
            #1;
            check($sformatf("v%0d_valid", v),   {30'd0, valid_o},   {30'd0, tbl[v].valid});
            check($sformatf("v%0d_elem", v),    {16'd0, element_o}, {16'd0, tbl[v].elem});
            check($sformatf("v%0d_credits", v), {26'd0, credits_o}, {26'd0, tbl[v].c1, tbl[v].c0});
            check($sformatf("v%0d_err", v),     {31'd0, err_o},     {31'd0, tbl[v].err});
        end

        // T6: refill one credit per link, then issue a pair and reset mid-stream
        empty_i  = 4'b1111;
        credit_i = 2'b11;
        @(posedge clk_i);
        #1;
        empty_i  = 4'b0000;
        credit_i = 2'b00;
        @(posedge clk_i);
        #1;
        check("pre_reset_valid", {30'd0, valid_o},   32'd3);
        check("pre_reset_elem",  {16'd0, element_o}, 32'h4433);
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_reset_valid",   {30'd0, valid_o},   32'd0);
        check("async_reset_elem",    {16'd0, element_o}, 32'd0);
        check("async_reset_credits", {26'd0, credits_o}, {26'd0, 3'd4, 3'd4});
        check("async_reset_pop",     {28'd0, pop_o},     32'd0);
        @(negedge clk_i);
        empty_i = 4'b1111;
        rst_ni  = 1'b1;

        // T5: credit return into a full counter sets the sticky error
        @(posedge clk_i);
        #1;
        credit_i = 2'b10;
        @(posedge clk_i);
        #1;
        check("overflow_credits", {26'd0, credits_o}, {26'd0, 3'd4, 3'd4});
        check("overflow_err",     {31'd0, err_o},     32'd1);
        credit_i = 2'b00;
        repeat (2) @(posedge clk_i);
        #1;
        check("overflow_err_sticky", {31'd0, err_o},     32'd1);
        check("overflow_valid_idle", {30'd0, valid_o},   32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
